axi_io_pmp_wr_guard: RTL and testbench

- Write-direction enforcement stage of the IO-PMP, placed between the DMA-facing AXI slave port and the memory-facing master port.
- For each AW it consumes the allow decision of an external write-check pmp instance (ACCESS_WRITE, PRIV_LVL_S), which evaluates slv_req_i.aw.addr.
- Allowed bursts go downstream. Denied bursts never reach the master: the guard absorbs their W beats and answers itself with B=SLVERR.
- AR/R channels pass straight through; read checking lives in the read-side block.

---
 rtl/axi_io_pmp_wr_guard.sv | 143 ++++++++++++++
 tb/tb_axi_io_pmp_wr_guard.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_io_pmp_wr_guard.sv
// axi_io_pmp_wr_guard: IO-PMP write enforcement; allowed bursts pass to the master,
// denied bursts are drained locally and answered with a SLVERR B.
package axi_io_pmp_wr_guard_pkg;
   typedef struct packed {
      logic [7:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [0:0]  user;
   } ax_chan_t;
   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
      logic [0:0]  user;
   } w_chan_t;
   typedef struct packed {
      logic [7:0] id;
      logic [1:0] resp;
      logic [0:0] user;
   } b_chan_t;
   typedef struct packed {
      logic [7:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [0:0]  user;
   } r_chan_t;
   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;
   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } rsp_t;
endpackage

module axi_io_pmp_wr_guard #(
   parameter int  ADDR_WIDTH = 64,
   parameter int  DATA_WIDTH = 64,
   parameter int  ID_WIDTH   = 8,
   parameter int  CNT_WIDTH  = 32,
   parameter type axi_req_t  = axi_io_pmp_wr_guard_pkg::req_t,
   parameter type axi_rsp_t  = axi_io_pmp_wr_guard_pkg::rsp_t
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  axi_req_t             slv_req_i,
   output axi_rsp_t             slv_resp_o,
   output axi_req_t             mst_req_o,
   input  axi_rsp_t             mst_resp_i,
   input  logic                 pmp_allow_i,
   output logic                 deny_o,
   output logic [CNT_WIDTH-1:0] deny_cnt_o
);
   typedef enum logic [2:0] {IDLE, FWD_W, WAIT_B, DRAIN, ERR_B} state_e;

   if ($bits(slv_req_i.aw.addr) != ADDR_WIDTH || $bits(slv_req_i.w.data) != DATA_WIDTH ||
       $bits(slv_req_i.aw.id) != ID_WIDTH) begin : g_width_err
      $error("axi_io_pmp_wr_guard: AXI struct widths disagree with parameters");
   end

   state_e               state_q;
   logic                 deny_q;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [7:0]           beat_q, len_q;
   logic [ID_WIDTH-1:0]  id_q;
   logic                 idle, err_b, aw_hs, w_hs, b_hs;

   assign idle  = state_q == IDLE;
   assign err_b = state_q == ERR_B;
   assign cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_WIDTH'(1);
   assign aw_hs = slv_req_i.aw_valid & slv_resp_o.aw_ready;
   assign w_hs  = slv_req_i.w_valid & slv_resp_o.w_ready;
   assign b_hs  = slv_resp_o.b_valid & slv_req_i.b_ready;
   assign deny_o     = deny_q;
   assign deny_cnt_o = cnt_q;

   // Read channels and all payloads pass straight through; only write handshakes are steered.
   always_comb begin
      mst_req_o          = slv_req_i;
      mst_req_o.aw_valid = idle & slv_req_i.aw_valid & pmp_allow_i;
      mst_req_o.w_valid  = (state_q == FWD_W) & slv_req_i.w_valid;
      mst_req_o.b_ready  = (state_q == WAIT_B) & slv_req_i.b_ready;
      slv_resp_o          = mst_resp_i;
      slv_resp_o.aw_ready = idle & slv_req_i.aw_valid & (pmp_allow_i ? mst_resp_i.aw_ready : 1'b1);
      slv_resp_o.w_ready  = (state_q == FWD_W) ? mst_resp_i.w_ready : state_q == DRAIN;
      slv_resp_o.b_valid  = (state_q == WAIT_B) ? mst_resp_i.b_valid : err_b;
      slv_resp_o.b.id     = err_b ? id_q : mst_resp_i.b.id;
      slv_resp_o.b.resp   = err_b ? 2'b10 : mst_resp_i.b.resp;
      slv_resp_o.b.user   = err_b ? '0 : mst_resp_i.b.user;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         deny_q  <= 1'b0;
         cnt_q   <= '0;
         beat_q  <= '0;
         len_q   <= '0;
         id_q    <= '0;
      end else begin
         deny_q <= 1'b0;
         case (state_q)
            IDLE: if (aw_hs) begin
               if (pmp_allow_i) state_q <= FWD_W;
               else begin
                  state_q <= DRAIN;
                  id_q    <= slv_req_i.aw.id;
                  len_q   <= slv_req_i.aw.len;
                  beat_q  <= '0;
                  deny_q  <= 1'b1;
                  cnt_q   <= cnt_d;
               end
            end
            FWD_W:  if (w_hs && slv_req_i.w.last) state_q <= WAIT_B;
            WAIT_B: if (b_hs) state_q <= IDLE;
            // Drain by beat count, not w.last, so a malformed burst cannot wedge the guard.
            DRAIN: if (w_hs) begin
               beat_q <= beat_q + 8'd1;
               if (beat_q == len_q) state_q <= ERR_B;
            end
            ERR_B:   if (b_hs) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_io_pmp_wr_guard.sv
// tb_axi_io_pmp_wr_guard: scoreboard bench; tasks drive the upstream master, an always
// block models the downstream slave and pops expected W beats and B responses.
module tb_axi_io_pmp_wr_guard;
   import axi_io_pmp_wr_guard_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic allow = 1'b0;
   req_t slv_req = '0;
   rsp_t mst_rsp = '0;
   req_t mst_req, mst_req2;
   rsp_t slv_rsp, slv_rsp2;
   logic deny, deny2;
   logic [31:0] cnt;
   logic [1:0] cnt2;
   int errors = 0, checks = 0;
   int pulses = 0, pulses2 = 0, mst_vld = 0, aw_hs_cnt = 0, aw_stall = 0, aw_wait = 0;
   bit outstanding = 0, b_pend = 0;
   bit m_aw, m_awv, m_w, m_wl, m_b, s_aw, s_b, rs;
   logic [7:0] ds_id = '0;
   w_chan_t exp_w_q[$];
   b_chan_t exp_b_q[$];
   w_chan_t ew;
   b_chan_t eb;

   always #5 clk = ~clk;

   axi_io_pmp_wr_guard #(.CNT_WIDTH(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .slv_req_i(slv_req), .slv_resp_o(slv_rsp),
      .mst_req_o(mst_req), .mst_resp_i(mst_rsp), .pmp_allow_i(allow),
      .deny_o(deny), .deny_cnt_o(cnt));

   axi_io_pmp_wr_guard #(.CNT_WIDTH(2)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .slv_req_i(slv_req), .slv_resp_o(slv_rsp2),
      .mst_req_o(mst_req2), .mst_resp_i(mst_rsp), .pmp_allow_i(allow),
      .deny_o(deny2), .deny_cnt_o(cnt2));

   // Monitor at negedge, downstream slave update just after posedge.
   always begin
      @(negedge clk);
      rs    = rst_n;
      m_aw  = mst_req.aw_valid && mst_rsp.aw_ready;
      m_awv = mst_req.aw_valid;
      m_w   = mst_req.w_valid && mst_rsp.w_ready;
      m_wl  = mst_req.w.last;
      m_b   = mst_rsp.b_valid && mst_req.b_ready;
      s_aw  = slv_req.aw_valid && slv_rsp.aw_ready;
      s_b   = slv_rsp.b_valid && slv_req.b_ready;
      if (!rs) begin
         exp_w_q.delete();
         exp_b_q.delete();
         outstanding = 0;
      end else begin
         if (deny) pulses++;
         if (deny2) pulses2++;
         if (mst_req.aw_valid || mst_req.w_valid) mst_vld++;
         if (s_aw) begin
            checks++;
            if (outstanding) begin
               errors++;
               $display("FAIL aw_while_busy got=1 exp=0 t=%0t", $time);
            end
            outstanding = 1;
            aw_hs_cnt++;
         end
         if (m_aw) begin
            ds_id = mst_req.aw.id;
            checks++;
            if (mst_req.aw !== slv_req.aw) begin
               errors++;
               $display("FAIL aw_payload got=%h exp=%h", mst_req.aw, slv_req.aw);
            end
         end
         if (m_w) begin
            checks++;
            if (exp_w_q.size() == 0) begin
               errors++;
               $display("FAIL w_unexpected got=%h exp=none", mst_req.w.data);
            end else begin
               ew = exp_w_q.pop_front();
               if (mst_req.w.data !== ew.data || mst_req.w.last !== ew.last) begin
                  errors++;
                  $display("FAIL w_beat got=%h/%b exp=%h/%b", mst_req.w.data, mst_req.w.last, ew.data, ew.last);
               end
            end
         end
         if (s_b) begin
            outstanding = 0;
            checks++;
            if (exp_b_q.size() == 0) begin
               errors++;
               $display("FAIL b_unexpected got=%h exp=none", slv_rsp.b);
            end else begin
               eb = exp_b_q.pop_front();
               if (slv_rsp.b !== eb) begin
                  errors++;
                  $display("FAIL b_resp got=%h exp=%h", slv_rsp.b, eb);
               end
            end
         end
      end
      @(posedge clk);
      #1;
      if (!rs) begin
         mst_rsp.aw_ready = 1'b0;
         mst_rsp.w_ready  = 1'b0;
         mst_rsp.b_valid  = 1'b0;
         aw_wait = 0;
         b_pend  = 0;
      end else begin
         if (m_aw) aw_wait = 0;
         else if (m_awv) aw_wait++;
         if (m_w && m_wl) b_pend = 1;
         if (m_b) b_pend = 0;
         mst_rsp.aw_ready = aw_wait >= aw_stall;
         mst_rsp.w_ready  = $urandom_range(0, 3) != 0;
         mst_rsp.b_valid  = b_pend;
         mst_rsp.b.id     = ds_id;
         mst_rsp.b.resp   = 2'b00;
         mst_rsp.b.user   = '0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic aw_phase(input logic [7:0] id, input logic [7:0] len, input logic a);
      int n = 0;
      bit hs = 0;
      b_chan_t b;
      slv_req.aw       = '0;
      slv_req.aw.id    = id;
      slv_req.aw.len   = len;
      slv_req.aw.addr  = {$urandom, $urandom};
      slv_req.aw.size  = 3'd3;
      slv_req.aw.burst = 2'b01;
      slv_req.aw_valid = 1'b1;
      allow = a;
      b.id = id;
      b.resp = a ? 2'b00 : 2'b10;
      b.user = '0;
      exp_b_q.push_back(b);
      while (!hs && n < 200) begin
         @(negedge clk);
         hs = slv_req.aw_valid && slv_rsp.aw_ready;
         n++;
      end
      checks++;
      if (!hs) begin
         errors++;
         $display("FAIL aw_timeout got=0 exp=1 id=%h", id);
      end
      cyc();
      slv_req.aw_valid = 1'b0;
      allow = !a;
   endtask

   task automatic w_phase(input logic [7:0] id, input logic [7:0] len, input int n_send,
                          input logic a, output int hs_cnt);
      w_chan_t beats[$];
      w_chan_t w;
      int n;
      bit hs;
      hs_cnt = 0;
      for (int i = 0; i < n_send; i++) begin
         w = '0;
         w.data = {id, 8'(i), 48'($urandom)};
         w.strb = '1;
         w.last = i == int'(len);
         beats.push_back(w);
         if (a) exp_w_q.push_back(w);
      end
      for (int i = 0; i < n_send; i++) begin
         slv_req.w = beats[i];
         slv_req.w_valid = 1'b1;
         hs = 0;
         n = 0;
         while (!hs && n < 200) begin
            @(negedge clk);
            hs = slv_req.w_valid && slv_rsp.w_ready;
            n++;
         end
         checks++;
         if (!hs) begin
            errors++;
            $display("FAIL w_timeout got=0 exp=1 id=%h beat=%0d", id, i);
            break;
         end
         hs_cnt++;
         cyc();
      end
      slv_req.w_valid = 1'b0;
   endtask

   task automatic b_phase(input int stall);
      int n = 0;
      slv_req.b_ready = 1'b0;
      do begin
         @(negedge clk);
         n++;
      end while (!slv_rsp.b_valid && n < 200);
      checks++;
      if (slv_rsp.b_valid !== 1'b1) begin
         errors++;
         $display("FAIL b_timeout got=%b exp=1", slv_rsp.b_valid);
      end
      for (int i = 0; i < stall; i++) begin
         cyc();
         @(negedge clk);
         checks++;
         if (slv_rsp.b_valid !== 1'b1) begin
            errors++;
            $display("FAIL b_hold got=%b exp=1", slv_rsp.b_valid);
         end
      end
      cyc();
      slv_req.b_ready = 1'b1;
      cyc();
      slv_req.b_ready = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] id, input logic [7:0] len, input logic a, input int bstall);
      int nb;
      fork
         aw_phase(id, len, a);
         w_phase(id, len, int'(len) + 1, a, nb);
      join
      b_phase(bstall);
   endtask

   task automatic test_reset();
      repeat (3) cyc();
      @(negedge clk);
      checks++;
      if (cnt !== 32'd0 || cnt2 !== 2'd0 || deny !== 1'b0) begin
         errors++;
         $display("FAIL reset_cnt got=%h/%h/%b exp=0/0/0", cnt, cnt2, deny);
      end
      checks++;
      if ({slv_rsp.aw_ready, slv_rsp.w_ready, slv_rsp.b_valid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_slv got=%b exp=000", {slv_rsp.aw_ready, slv_rsp.w_ready, slv_rsp.b_valid});
      end
      checks++;
      if ({mst_req.aw_valid, mst_req.w_valid, mst_req.b_ready} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mst got=%b exp=000", {mst_req.aw_valid, mst_req.w_valid, mst_req.b_ready});
      end
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_ar_r();
      ax_chan_t ar;
      r_chan_t r;
      ar = '0;
      ar.id = 8'h3C;
      ar.addr = {$urandom, $urandom};
      ar.len = 8'd7;
      r = '0;
      r.id = 8'h3C;
      r.data = {$urandom, $urandom};
      r.last = 1'b1;
      slv_req.ar = ar;
      slv_req.ar_valid = 1'b1;
      slv_req.r_ready = 1'b1;
      mst_rsp.r = r;
      mst_rsp.r_valid = 1'b1;
      mst_rsp.ar_ready = 1'b1;
      #1;
      checks++;
      if (mst_req.ar !== ar || {mst_req.ar_valid, mst_req.r_ready} !== 2'b11) begin
         errors++;
         $display("FAIL ar_pass got=%h exp=%h", mst_req.ar, ar);
      end
      checks++;
      if (slv_rsp.r !== r || {slv_rsp.r_valid, slv_rsp.ar_ready} !== 2'b11) begin
         errors++;
         $display("FAIL r_pass got=%h exp=%h", slv_rsp.r, r);
      end
      slv_req.ar_valid = 1'b0;
      slv_req.r_ready = 1'b0;
      mst_rsp.r_valid = 1'b0;
      mst_rsp.ar_ready = 1'b0;
      cyc();
   endtask

   task automatic test_single();
      int p = pulses;
      do_write(8'h05, 8'd0, 1'b1, 0);
      @(negedge clk);
      checks++;
      if (cnt !== 32'd0 || pulses != p) begin
         errors++;
         $display("FAIL single_deny got=%0d/%0d exp=0/0", cnt, pulses - p);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      int k = aw_hs_cnt;
      int n1, n2;
      aw_stall = 3;
      fork
         begin
            fork
               aw_phase(8'h21, 8'd3, 1'b1);
               w_phase(8'h21, 8'd3, 4, 1'b1, n1);
            join
            b_phase(3);
         end
         begin
            wait (aw_hs_cnt == k + 1);
            @(posedge clk);
            #2;
            aw_phase(8'h22, 8'd1, 1'b1);
            w_phase(8'h22, 8'd1, 2, 1'b1, n2);
            b_phase(0);
         end
      join
      aw_stall = 0;
      checks++;
      if (n1 != 4 || n2 != 2 || aw_hs_cnt != k + 2) begin
         errors++;
         $display("FAIL b2b_beats got=%0d/%0d/%0d exp=4/2/2", n1, n2, aw_hs_cnt - k);
      end
      checks++;
      if (exp_w_q.size() != 0 || exp_b_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_lost got=%0d/%0d exp=0/0", exp_w_q.size(), exp_b_q.size());
      end
   endtask

   task automatic test_w_early();
      int n;
      fork
         w_phase(8'h33, 8'd2, 3, 1'b1, n);
         begin
            repeat (2) begin
               @(negedge clk);
               checks++;
               if (slv_rsp.w_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL w_early_ready got=%b exp=0", slv_rsp.w_ready);
               end
               cyc();
            end
            aw_phase(8'h33, 8'd2, 1'b1);
         end
      join
      b_phase(0);
      checks++;
      if (n != 3 || exp_w_q.size() != 0) begin
         errors++;
         $display("FAIL w_early_beats got=%0d/%0d exp=3/0", n, exp_w_q.size());
      end
   endtask

   task automatic test_deny();
      int p = pulses;
      int v = mst_vld;
      int n;
      fork
         aw_phase(8'hA3, 8'd3, 1'b0);
         w_phase(8'hA3, 8'd3, 4, 1'b0, n);
      join
      b_phase(3);
      @(negedge clk);
      checks++;
      if (n != 4 || mst_vld != v) begin
         errors++;
         $display("FAIL deny_drain got=%0d/%0d exp=4/0", n, mst_vld - v);
      end
      checks++;
      if (pulses - p != 1 || cnt !== 32'd1) begin
         errors++;
         $display("FAIL deny_count got=%0d/%0d exp=1/1", pulses - p, cnt);
      end
      cyc();
   endtask

   task automatic test_saturate();
      int p2;
      int n;
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      p2 = pulses2;
      for (int i = 1; i <= 5; i++) begin
         fork
            aw_phase(8'(i), 8'd0, 1'b0);
            w_phase(8'(i), 8'd0, 1, 1'b0, n);
         join
         b_phase(0);
         @(negedge clk);
         checks++;
         if (cnt2 !== 2'((i > 3) ? 3 : i) || cnt !== 32'(i)) begin
            errors++;
            $display("FAIL sat_cnt got=%0d/%0d exp=%0d/%0d", cnt2, cnt, (i > 3) ? 3 : i, i);
         end
         cyc();
      end
      checks++;
      if (pulses2 - p2 != 5) begin
         errors++;
         $display("FAIL sat_pulses got=%0d exp=5", pulses2 - p2);
      end
   endtask

   task automatic test_reset_drain();
      int n;
      fork
         aw_phase(8'h7C, 8'd3, 1'b0);
         w_phase(8'h7C, 8'd3, 2, 1'b0, n);
      join
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({slv_rsp.b_valid, slv_rsp.w_ready, mst_req.aw_valid, mst_req.w_valid} !== 4'b0000 || cnt !== 32'd0) begin
         errors++;
         $display("FAIL rst_drain got=%b/%0d exp=0000/0",
                  {slv_rsp.b_valid, slv_rsp.w_ready, mst_req.aw_valid, mst_req.w_valid}, cnt);
      end
      cyc();
      do_write(8'h11, 8'd1, 1'b1, 1);
      @(negedge clk);
      checks++;
      if (exp_w_q.size() != 0 || exp_b_q.size() != 0 || cnt !== 32'd0) begin
         errors++;
         $display("FAIL rst_recover got=%0d/%0d/%0d exp=0/0/0", exp_w_q.size(), exp_b_q.size(), cnt);
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_ar_r();
      test_single();
      test_back_to_back();
      test_w_early();
      test_deny();
      test_saturate();
      test_reset_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
